icache_2way: RTL

//  Parametrised 2-way set-associative, read-only instruction cache between the CPU fetch port and the
//  128-bit-class memory/L2 bus. Hit: word returned the same cycle (combinational), no stall.

---
 rtl/icache_2way_pkg.sv | 11 +
 rtl/icache_2way_way.sv | 69 ++++++
 rtl/icache_2way.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/icache_2way_pkg.sv
// Types and constants shared by the 2-way instruction cache and its way arrays.
package icache_2way_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        COMP   = 1'b0,
        REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_2way_way.sv
// One cache way: valid/tag/data per set, combinational hit and word select, fill port, invalidate-all.
module icache_2way_way
    import icache_2way_pkg::*;
#(
    parameter int WORDS_PER_BLK = 4,
    parameter int NUM_SETS      = 4,
    parameter int TAG_W         = 26,
    localparam int OFF_W        = $clog2(WORDS_PER_BLK),
    localparam int IDX_W        = $clog2(NUM_SETS),
    localparam int BLK_W        = WORD_W * WORDS_PER_BLK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              hit,
    output logic [WORD_W-1:0] rd_word,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [BLK_W-1:0]  fill_data,
    input  logic              inv_all
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_d  [NUM_SETS];
    logic [BLK_W-1:0]    data_q [NUM_SETS];
    logic [BLK_W-1:0]    data_d [NUM_SETS];

    // Invalidate is applied after the fill so a flush also kills the line being written.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_data;
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    always_comb begin
        rd_word = '0;
        if (hit) begin
            rd_word = data_q[rd_idx][WORD_W*int'(rd_off) +: WORD_W];
        end
    end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative read-only instruction cache with LRU victim choice, flush and perf counters.
//  state  | meaning
//  COMP   | lookup; hits served combinationally, a miss latches the block and victim
//  REFILL | block read outstanding on the memory bus; fetch stalled until mem_ready
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int ADDR_W        = 30,
    parameter int WORDS_PER_BLK = 4,
    parameter int NUM_SETS      = 4,
    parameter int CNT_W         = 32,
    localparam int OFF_W        = $clog2(WORDS_PER_BLK),
    localparam int IDX_W        = $clog2(NUM_SETS),
    localparam int TAG_W        = ADDR_W - IDX_W - OFF_W,
    localparam int BA_W         = ADDR_W - OFF_W,
    localparam int BLK_W        = WORD_W * WORDS_PER_BLK
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              proc_read,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_stall,
    input  logic              flush,
    output logic              mem_read,
    output logic [BA_W-1:0]   mem_addr,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  access_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;
    logic [BA_W-1:0]     blk_addr_q, blk_addr_d;
    logic                victim_q, victim_d;
    logic                flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]    access_cnt_q, access_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit_w0, hit_w1, hit;
    logic [WORD_W-1:0] word_w0, word_w1;
    logic              fill_go, inv_all;

    assign req_off  = proc_addr[OFF_W-1:0];
    assign req_idx  = proc_addr[OFF_W +: IDX_W];
    assign req_tag  = proc_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = blk_addr_q[IDX_W-1:0];
    assign fill_tag = blk_addr_q[BA_W-1 -: TAG_W];

    icache_2way_way #(.WORDS_PER_BLK(WORDS_PER_BLK), .NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst_n(proc_reset_n),
        .rd_idx(req_idx), .rd_tag(req_tag), .rd_off(req_off),
        .hit(hit_w0), .rd_word(word_w0),
        .fill_en(fill_go && !victim_q), .fill_idx(fill_idx), .fill_tag(fill_tag),
        .fill_data(mem_rdata), .inv_all(inv_all)
    );

    icache_2way_way #(.WORDS_PER_BLK(WORDS_PER_BLK), .NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst_n(proc_reset_n),
        .rd_idx(req_idx), .rd_tag(req_tag), .rd_off(req_off),
        .hit(hit_w1), .rd_word(word_w1),
        .fill_en(fill_go && victim_q), .fill_idx(fill_idx), .fill_tag(fill_tag),
        .fill_data(mem_rdata), .inv_all(inv_all)
    );

    assign hit        = hit_w0 | hit_w1;
    assign proc_rdata = word_w0 | word_w1;
    assign mem_addr   = blk_addr_q;
    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        lru_d        = lru_q;
        blk_addr_d   = blk_addr_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        access_cnt_d = access_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_go      = 1'b0;
        inv_all      = flush;
        mem_read     = 1'b0;
        proc_stall   = 1'b0;
        case (state_q)
            COMP: begin
                proc_stall = proc_read && (!hit || flush);
                // LRU bit names the victim: a way0 hit makes way1 the next victim.
                if (proc_read && hit) begin
                    lru_d[req_idx] = hit_w0;
                end
                if (proc_read && !hit && !flush) begin
                    blk_addr_d = proc_addr[ADDR_W-1:OFF_W];
                    victim_d   = lru_q[req_idx];
                    state_d    = REFILL;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            REFILL: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ready) begin
                    fill_go           = 1'b1;
                    inv_all           = flush || flush_pend_q;
                    lru_d[fill_idx]   = ~victim_q;
                    flush_pend_d      = 1'b0;
                    state_d           = COMP;
                end
            end
            default: state_d = COMP;
        endcase
        if (proc_read && !proc_stall && (access_cnt_q != '1)) begin
            access_cnt_d = access_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q      <= COMP;
            lru_q        <= '0;
            blk_addr_q   <= '0;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lru_q        <= lru_d;
            blk_addr_q   <= blk_addr_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    a_one_hit: assert property (@(posedge clk) disable iff (!proc_reset_n) !(hit_w0 && hit_w1));

endmodule
